// File: rtl/param_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB, bimodal counter table and a
// circular return-address stack. Lookup is combinational; training happens on the clock edge.
module param_predictor #(
  parameter int PC_W        = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8,
  parameter int CNT_W       = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           pred_valid,
  input  logic [PC_W-1:0]                pc,
  input  logic                           upd_valid,
  input  logic [PC_W-1:0]                upd_pc,
  input  logic                           upd_taken,
  input  logic [PC_W-1:0]                upd_target,
  input  logic [1:0]                     upd_type,
  output logic                           pred_jump,
  output logic [PC_W-1:0]                pred_target,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  localparam int RAS_CW = RAS_PW + 1;
  localparam int TAG_W  = PC_W - BTB_IW - 2;

  localparam logic [1:0]        TYPE_COND = 2'b00;
  localparam logic [1:0]        TYPE_CALL = 2'b10;
  localparam logic [1:0]        TYPE_RET  = 2'b11;
  localparam logic [CNT_W-1:0]  CNT_INIT  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [RAS_CW-1:0] RAS_FULL  = RAS_CW'(RAS_DEPTH);

  logic              btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
  logic [PC_W-1:0]   btb_target [BTB_ENTRIES];
  logic [1:0]        btb_type   [BTB_ENTRIES];
  logic [CNT_W-1:0]  bht_cnt    [BHT_ENTRIES];
  logic [PC_W-1:0]   ras_mem    [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr;
  logic [RAS_CW-1:0] ras_cnt;

  logic [BTB_IW-1:0] lk_btb_idx;
  logic [BHT_IW-1:0] lk_bht_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [RAS_PW-1:0] ras_top_idx;
  logic              lk_hit;
  logic [BTB_IW-1:0] up_btb_idx;
  logic [BHT_IW-1:0] up_bht_idx;
  logic              btb_write;
  logic              unused_pc_bits;

  assign lk_btb_idx     = pc[BTB_IW+1:2];
  assign lk_bht_idx     = pc[BHT_IW+1:2];
  assign lk_tag         = pc[PC_W-1:BTB_IW+2];
  assign ras_top_idx    = RAS_PW'(ras_ptr - 1'b1);
  assign lk_hit         = pred_valid && btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
  assign up_btb_idx     = upd_pc[BTB_IW+1:2];
  assign up_bht_idx     = upd_pc[BHT_IW+1:2];
  assign btb_write      = (upd_type != TYPE_COND) || upd_taken;
  assign ras_count      = ras_cnt;
  assign unused_pc_bits = ^pc[1:0];

  // Reads the registered tables only, so a same-cycle update is never bypassed.
  always_comb begin
    pred_jump   = 1'b0;
    pred_target = '0;
    if (lk_hit) begin
      case (btb_type[lk_btb_idx])
        TYPE_COND: begin
          pred_jump   = bht_cnt[lk_bht_idx][CNT_W-1];
          pred_target = btb_target[lk_btb_idx];
        end
        TYPE_RET: begin
          if (ras_cnt != '0) begin
            pred_jump   = 1'b1;
            pred_target = ras_mem[ras_top_idx];
          end
        end
        default: begin
          pred_jump   = 1'b1;
          pred_target = btb_target[lk_btb_idx];
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_cnt[i] <= CNT_INIT;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (upd_valid) begin
      if (upd_type == TYPE_COND) begin
        if (upd_taken && bht_cnt[up_bht_idx] != CNT_MAX)
          bht_cnt[up_bht_idx] <= bht_cnt[up_bht_idx] + 1'b1;
        else if (!upd_taken && bht_cnt[up_bht_idx] != '0)
          bht_cnt[up_bht_idx] <= bht_cnt[up_bht_idx] - 1'b1;
      end
      if (btb_write) begin
        btb_valid[up_btb_idx]  <= 1'b1;
        btb_tag[up_btb_idx]    <= upd_pc[PC_W-1:BTB_IW+2];
        btb_target[up_btb_idx] <= upd_target;
        btb_type[up_btb_idx]   <= upd_type;
      end
      // ras_ptr names the next free slot; a push when full silently replaces the oldest.
      if (upd_type == TYPE_CALL) begin
        ras_mem[ras_ptr] <= upd_pc + PC_W'(4);
        ras_ptr          <= RAS_PW'(ras_ptr + 1'b1);
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (upd_type == TYPE_RET && ras_cnt != '0) begin
        ras_ptr <= ras_top_idx;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_predictor.sv
// Bench for param_predictor: directed scenarios then randomized traffic, all checked
// against a table/queue model of the predictor's behaviour.
module tb_param_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [63:0] pc;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic [1:0]  upd_type;
  logic        pred_jump;
  logic [63:0] pred_target;
  logic [3:0]  ras_count;

  int checks = 0;
  int failures = 0;

  param_predictor dut (
    .clock(clock), .reset(reset), .pred_valid(pred_valid), .pc(pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_type(upd_type),
    .pred_jump(pred_jump), .pred_target(pred_target), .ras_count(ras_count)
  );

  always #5 clock = ~clock;

  // Reference model: BTB keyed by index holding the full upper-PC tag, plain int counters,
  // and the RAS as a queue whose back is the top of stack.
  typedef struct {
    bit          v;
    logic [63:0] tag;
    logic [63:0] tgt;
    logic [1:0]  ty;
  } btb_e;

  btb_e        m_btb[16];
  int          m_cnt[64];
  logic [63:0] m_ras[$];

  logic        obs_jump;
  logic [63:0] obs_tgt;
  logic [3:0]  obs_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_btb[i].v = 0;
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    m_ras.delete();
  endtask

  task automatic model_predict(input logic pv, input logic [63:0] p,
                               output logic j, output logic [63:0] t);
    int bi;
    j = 0;
    t = 0;
    bi = int'((p / 4) % 16);
    if (pv && m_btb[bi].v && m_btb[bi].tag == (p / 64)) begin
      case (m_btb[bi].ty)
        2'b00: begin j = (m_cnt[int'((p / 4) % 64)] >= 2); t = m_btb[bi].tgt; end
        2'b11: if (m_ras.size() > 0) begin j = 1; t = m_ras[$]; end
        default: begin j = 1; t = m_btb[bi].tgt; end
      endcase
    end
  endtask

  task automatic model_update(input logic rst, input logic uv, input logic [63:0] up,
                              input logic tk, input logic [63:0] ut, input logic [1:0] ty);
    int bi;
    int ci;
    if (rst) begin
      model_reset();
    end else if (uv) begin
      bi = int'((up / 4) % 16);
      ci = int'((up / 4) % 64);
      if (ty == 2'b00) m_cnt[ci] = tk ? ((m_cnt[ci] < 3) ? m_cnt[ci] + 1 : 3)
                                      : ((m_cnt[ci] > 0) ? m_cnt[ci] - 1 : 0);
      if (ty != 2'b00 || tk) begin
        m_btb[bi].v = 1;
        m_btb[bi].tag = up / 64;
        m_btb[bi].tgt = ut;
        m_btb[bi].ty = ty;
      end
      if (ty == 2'b10) begin
        m_ras.push_back(up + 64'd4);
        if (m_ras.size() > 8) m_ras.delete(0);
      end else if (ty == 2'b11 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  // One clock: drive, compare the lookup against the model at negedge, then advance both.
  task automatic cycle(input logic rst, input logic pv, input logic [63:0] p,
                       input logic uv, input logic [63:0] up, input logic tk,
                       input logic [63:0] ut, input logic [1:0] ty);
    logic        ej;
    logic [63:0] et;
    reset = rst; pred_valid = pv; pc = p;
    upd_valid = uv; upd_pc = up; upd_taken = tk; upd_target = ut; upd_type = ty;
    @(negedge clock);
    model_predict(pv, p, ej, et);
    obs_jump = pred_jump;
    obs_tgt  = pred_target;
    obs_cnt  = ras_count;
    check("pred_jump", 64'(obs_jump), 64'(ej));
    check("pred_target", obs_tgt, et);
    check("ras_count", 64'(obs_cnt), 64'(m_ras.size()));
    @(posedge clock);
    model_update(rst, uv, up, tk, ut, ty);
    #1;
  endtask

  task automatic lookup(input logic [63:0] p);
    cycle(0, 1, p, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [63:0] up, input logic tk, input logic [63:0] ut,
                     input logic [1:0] ty);
    cycle(0, 0, 0, 1, up, tk, ut, ty);
  endtask

  function automatic logic [63:0] rand_pc();
    return 64'h8000_0000 | (64'($urandom_range(0, 2)) << 6) | (64'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    reset = 1; pred_valid = 0; pc = 0; upd_valid = 0; upd_pc = 0;
    upd_taken = 0; upd_target = 0; upd_type = 0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();

    // Cold lookup after reset
    lookup(64'h8000_0000);
    check("cold_jump", 64'(obs_jump), 0);
    check("cold_target", obs_tgt, 0);
    check("cold_ras", 64'(obs_cnt), 0);

    // Conditional training up then down
    upd(64'h8000_0010, 1, 64'h8000_0100, 2'b00);
    upd(64'h8000_0010, 1, 64'h8000_0100, 2'b00);
    lookup(64'h8000_0010);
    check("cond_taken_jump", 64'(obs_jump), 1);
    check("cond_taken_target", obs_tgt, 64'h8000_0100);
    upd(64'h8000_0010, 0, 64'h0, 2'b00);
    upd(64'h8000_0010, 0, 64'h0, 2'b00);
    lookup(64'h8000_0010);
    check("cond_nt_jump", 64'(obs_jump), 0);

    // Same index, different tag must miss
    upd(64'h8000_0010, 1, 64'h8000_0100, 2'b00);
    upd(64'h8000_0010, 1, 64'h8000_0100, 2'b00);
    lookup(64'h8000_0050);
    check("alias_jump", 64'(obs_jump), 0);
    check("alias_target", obs_tgt, 0);

    // Call/return pairing; ret entry stored while the RAS is empty
    upd(64'h8000_0200, 1, 64'h0, 2'b11);
    upd(64'h8000_0020, 1, 64'h8000_0200, 2'b10);
    lookup(64'h8000_0200);
    check("ret_jump", 64'(obs_jump), 1);
    check("ret_target", obs_tgt, 64'h8000_0024);
    check("ret_ras_count", 64'(obs_cnt), 1);
    upd(64'h8000_0200, 1, 64'h0, 2'b11);
    lookup(64'h8000_0200);
    check("ret_empty_jump", 64'(obs_jump), 0);
    check("ret_empty_count", 64'(obs_cnt), 0);

    // RAS overflow: nine calls, then pops with a same-cycle lookup of the ret entry
    upd(64'h2008, 1, 64'h0, 2'b11);
    for (int k = 0; k < 9; k++) upd(64'h1000 + 64'(16 * k), 1, 64'h3000, 2'b10);
    lookup(64'h2008);
    check("ovf_count", 64'(obs_cnt), 8);
    check("ovf_top", obs_tgt, 64'h1084);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 64'h2008, 1, 64'h2008, 1, 64'h0, 2'b11);
      check("pop_target", obs_tgt, 64'h1084 - 64'(16 * k));
    end
    cycle(0, 1, 64'h2008, 1, 64'h2008, 1, 64'h0, 2'b11);
    check("pop_empty_jump", 64'(obs_jump), 0);
    lookup(64'h2008);
    check("pop_empty_count", 64'(obs_cnt), 0);

    // Reset wins over a simultaneous call update
    upd(64'h1080, 1, 64'h4000, 2'b10);
    lookup(64'h1080);
    check("pre_reset_hit", 64'(obs_jump), 1);
    cycle(1, 0, 0, 1, 64'h1090, 1, 64'h5000, 2'b10);
    lookup(64'h1080);
    check("post_reset_jump", 64'(obs_jump), 0);
    check("post_reset_target", obs_tgt, 0);
    check("post_reset_count", 64'(obs_cnt), 0);

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), rand_pc(),
            ($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 1)),
            {$urandom, $urandom} & ~64'h3, 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_predictor.md
PARAM_PREDICTOR -- requirements
Module: param_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 64, PC and target width.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, BTB entries (power of 2, >=2).
REQ-003 SHALL have parameter BHT_ENTRIES, default 64, direction counters (power of 2, >=2).
REQ-004 SHALL have parameter RAS_DEPTH, default 8, return-address stack entries (power of 2, >=2).
REQ-005 SHALL have parameter CNT_W, default 2, saturating counter width (>=2).
REQ-006 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port pred_valid  input  1  fetch lookup enable (pc_ready & ~nop).
REQ-009 SHALL have port pc  input  PC_W  fetch PC to predict.
REQ-010 SHALL have port upd_valid  input  1  resolved control-flow instruction from ID.
REQ-011 SHALL have port upd_pc  input  PC_W  PC of resolved instruction.
REQ-012 SHALL have port upd_taken  input  1  actual direction.
REQ-013 SHALL have port upd_target  input  PC_W  actual target.
REQ-014 SHALL have port upd_type  input  2  00 cond branch, 01 direct/indirect jump, 10 call, 11 ret.
REQ-015 SHALL have port pred_jump  output  1  predicted taken.
REQ-016 SHALL have port pred_target  output  PC_W  predicted target.
REQ-017 SHALL have port ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.

Function
REQ-018 SHALL index BTB with pc[clog2(BTB_ENTRIES)+1:2] and BHT with pc[clog2(BHT_ENTRIES)+1:2]; tag = remaining upper bits above the BTB index.
REQ-019 SHALL perform lookup combinationally in the same cycle as pc (zero latency); updates visible from the next cycle, no write-to-read bypass.
REQ-020 SHALL define BTB hit = entry valid and tag match; on miss or pred_valid=0, pred_jump=0 and pred_target=0.
REQ-021 SHALL predict on hit: cond -> pred_jump = counter MSB, pred_target = BTB target; jump/call -> pred_jump=1, BTB target; ret -> pred_jump=1 with RAS top if ras_count>0, else pred_jump=0.
REQ-022 SHALL, on upd_valid cond, increment counter if taken (saturate at all-ones) else decrement (saturate at 0).
REQ-023 SHALL, on upd_valid, write BTB entry (valid, tag, upd_target, upd_type) when upd_type!=00 or upd_taken=1; cond not-taken SHALL NOT allocate or invalidate.
REQ-024 SHALL, on call, push upd_pc+4 (mod 2^PC_W) onto RAS; on full, overwrite oldest entry circularly, ras_count stays RAS_DEPTH.
REQ-025 SHALL, on ret with ras_count>0, pop (pointer -1, count -1); ret on empty RAS SHALL leave RAS unchanged.
REQ-026 SHALL keep RAS top pointer wrapping modulo RAS_DEPTH on both push and pop.
REQ-027 SHALL accept at most one update per cycle; lookup and update to the same index in one cycle: lookup returns pre-update contents.
REQ-028 SHALL ignore upd_* fields when upd_valid=0; state SHALL be unaffected by pred_valid.

Reset
REQ-029 SHALL, while reset=1 at an edge, clear all BTB valid bits, set all counters to weakly-not-taken (2^(CNT_W-1)-1), set RAS pointer and ras_count to 0.
REQ-030 SHALL give reset priority over a simultaneous upd_valid; that update is discarded.
REQ-031 SHALL drive pred_jump=0, pred_target=0, ras_count=0 in the cycle after reset regardless of pc.

Verification
REQ-032 Cold lookup: after reset, pred_valid=1, pc=0x8000_0000 -> pred_jump=0, pred_target=0.
REQ-033 Cond training: update pc=0x8000_0010 cond taken target 0x8000_0100 twice -> next lookup at 0x8000_0010 gives pred_jump=1, pred_target=0x8000_0100; two not-taken updates -> pred_jump=0.
REQ-034 Aliasing: train 0x8000_0010, lookup 0x8000_0050 (same index, different tag) -> pred_jump=0.
REQ-035 Call/ret: call at 0x8000_0020 (BTB target 0x8000_0200), ret at 0x8000_0200 stored -> lookup at 0x8000_0200 gives pred_jump=1, pred_target=0x8000_0024, ras_count=1; ret update -> ras_count=0, lookup gives pred_jump=0.
REQ-036 RAS overflow: 9 calls from 0x1000,0x1010,...,0x1080 -> ras_count=8, top=0x1084; 8 pops return 0x1084 down to 0x1014; 9th pop leaves count 0.
REQ-037 Reset mid-operation: reset=1 with simultaneous upd_valid call -> ras_count=0, all prior BTB hits gone next cycle.
